// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store unit: opcodes, Funct3 size codes, FSM states.
package lsu_pkg;

  localparam logic [4:0] OP_LOAD  = 5'b10100;
  localparam logic [4:0] OP_STORE = 5'b10101;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE,
    S_ERR
  } state_t;

  // Loads accept signed and unsigned sizes; stores only B/H/W.
  function automatic logic f3_legal(input logic is_load, input logic [2:0] f3);
    if (is_load)
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables and store replication for the outgoing
// access, byte/half extraction and sign/zero extension for the returning word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  st_addr,
  input  logic [2:0]  st_f3,
  input  logic [31:0] st_data,
  input  logic [1:0]  ld_addr,
  input  logic [2:0]  ld_f3,
  input  logic [31:0] ld_rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    be    = 4'b1111;
    wdata = st_data;
    case (st_f3[1:0])
      2'b00: begin
        be    = 4'b0001 << st_addr;
        wdata = {4{st_data[7:0]}};
      end
      2'b01: begin
        be    = 4'b0011 << {st_addr[1], 1'b0};
        wdata = {2{st_data[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = st_data;
      end
    endcase
  end

  // Misaligned low bits are dropped here; halves follow addr[1] and words use lane 0.
  always_comb begin
    ld_byte = 8'(ld_rdata >> {ld_addr, 3'b000});
    ld_half = 16'(ld_rdata >> {ld_addr[1], 4'b0000});
    case (ld_f3)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_BU:   ld_data = {24'h0, ld_byte};
      F3_HU:   ld_data = {16'h0, ld_half};
      default: ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one memory op from execute, runs a single bus
// transaction with timeout. Define LSU_MISALIGN_TRAP_EN to abort misaligned H/W accesses.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [4:0]  ALUop_i,
  input  logic [31:0] ALUOut_i,
  input  logic [2:0]  Funct3_i,
  input  logic [31:0] StoreData_i,
  output logic        stall_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] LoadData_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [15:0] wait_cnt;
  logic [1:0]  addr_lo_q;
  logic [2:0]  f3_q;

  logic        is_load, is_store, is_mem, f3_ok, misalign, timeout_hit;
  logic [3:0]  be_st;
  logic [31:0] wdata_st, ld_data;

  lsu_align u_align (
    .st_addr  (ALUOut_i[1:0]),
    .st_f3    (Funct3_i),
    .st_data  (StoreData_i),
    .ld_addr  (addr_lo_q),
    .ld_f3    (f3_q),
    .ld_rdata (mem_rdata_i),
    .be       (be_st),
    .wdata    (wdata_st),
    .ld_data  (ld_data)
  );

  always_comb begin
    is_load     = (ALUop_i == OP_LOAD);
    is_store    = (ALUop_i == OP_STORE);
    is_mem      = valid_i && (is_load || is_store);
    f3_ok       = f3_legal(is_load, Funct3_i);
    timeout_hit = (wait_cnt == WAIT_LAST);
`ifdef LSU_MISALIGN_TRAP_EN
    misalign = ((Funct3_i[1:0] == 2'b01) && ALUOut_i[0]) ||
               ((Funct3_i[1:0] == 2'b10) && (ALUOut_i[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
  end

  always_comb begin
    state_nxt = state;
    stall_o   = 1'b0;
    done_o    = (state == S_DONE);
    err_o     = (state == S_ERR);
    case (state)
      S_IDLE: begin
        if (is_mem) begin
          stall_o   = 1'b1;
          state_nxt = (!f3_ok || misalign) ? S_ERR : S_REQ;
        end
      end
      S_REQ: begin
        stall_o = 1'b1;
        if (mem_ack_i)        state_nxt = S_DONE;
        else if (timeout_hit) state_nxt = S_ERR;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bus outputs are registered; address/be/wdata stay stable from acceptance until the next access.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      addr_lo_q   <= '0;
      f3_q        <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_be_o    <= '0;
      mem_wdata_o <= '0;
      LoadData_o  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          wait_cnt <= '0;
          if (state_nxt == S_REQ) begin
            mem_req_o   <= 1'b1;
            mem_we_o    <= is_store;
            mem_addr_o  <= {ALUOut_i[31:2], 2'b00};
            mem_be_o    <= be_st;
            mem_wdata_o <= wdata_st;
            addr_lo_q   <= ALUOut_i[1:0];
            f3_q        <= Funct3_i;
          end
        end
        S_REQ: begin
          if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            mem_we_o  <= 1'b0;
            if (!mem_we_o) LoadData_o <= ld_data;
          end else if (timeout_hit) begin
            mem_req_o <= 1'b0;
            mem_we_o  <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        default: wait_cnt <= '0;
      endcase
    end
  end

endmodule
